// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer control slice.
package timer_pkg;

  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] MAX_MMSS = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Increment a minutes/seconds field, wrapping 59 back to 0.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v);
    return (v == MAX_MMSS) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/timer_control_btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stable-level debouncer and
// a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // NOTE: every register here updates with <= so all of them sample the
  // pre-edge values; blocking assignments would collapse the sync chain.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      pulse      <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEB_CYC - 1)) begin
        // The new level has now been seen DEB_CYC cycles in a row.
        level      <= sync2;
        stable_cnt <= '0;
        pulse      <= sync2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_control.sv
// Sequencing controller for the mm:ss countdown: button handling, preset
// editing, run/pause/alarm FSM and registered strobes for the counter chain.
module timer_control
  import timer_pkg::*;
#(
  parameter int DEB_CYC        = 16,
  parameter int ALARM_TICKS    = 10,
  parameter int PRESET_MIN_DEF = 1,
  parameter int PRESET_SEC_DEF = 0
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               btn_start,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               cnt_zero,
  output logic               cnt_en,
  output logic               cnt_load,
  output logic               cnt_clr,
  output logic [FIELD_W-1:0] load_min,
  output logic [FIELD_W-1:0] load_sec,
  output logic               blink_min,
  output logic               blink_sec,
  output logic               alarm,
  output logic [2:0]         state_dbg
);

  localparam int ACW = $clog2(ALARM_TICKS + 1);

  logic start_p, mode_p, inc_p;
  logic ev_start, ev_mode, ev_inc;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .clk_in(clk_in), .reset(reset), .btn(btn_start), .pulse(start_p));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk_in(clk_in), .reset(reset), .btn(btn_mode), .pulse(mode_p));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk_in(clk_in), .reset(reset), .btn(btn_inc), .pulse(inc_p));

  // Same-cycle presses: start wins over mode, mode wins over inc.
  assign ev_start = start_p;
  assign ev_mode  = mode_p & ~start_p;
  assign ev_inc   = inc_p & ~start_p & ~mode_p;

  state_t             state, state_nx;
  logic [FIELD_W-1:0] preset_min, preset_min_nx;
  logic [FIELD_W-1:0] preset_sec, preset_sec_nx;
  logic [ACW-1:0]     alarm_cnt, alarm_cnt_nx;
  logic               blink_ph, blink_ph_nx;
  logic               en_nx, load_nx, clr_nx;

  assign blink_ph_nx = blink_ph ^ tick_1hz;

  // NOTE: every variable gets its default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    preset_min_nx = preset_min;
    preset_sec_nx = preset_sec;
    alarm_cnt_nx  = alarm_cnt;
    en_nx         = 1'b0;
    load_nx       = 1'b0;
    clr_nx        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_start) begin
          if (preset_min != '0 || preset_sec != '0) begin
            state_nx = ST_RUN;
            load_nx  = 1'b1;
          end
        end else if (ev_mode) begin
          state_nx = ST_SET_MIN;
        end
      end
      ST_SET_MIN: begin
        if (ev_mode)     state_nx      = ST_SET_SEC;
        else if (ev_inc) preset_min_nx = wrap_inc(preset_min);
      end
      ST_SET_SEC: begin
        if (ev_mode)     state_nx      = ST_IDLE;
        else if (ev_inc) preset_sec_nx = wrap_inc(preset_sec);
      end
      ST_RUN: begin
        en_nx = tick_1hz & ~cnt_zero;
        if (cnt_zero) begin
          state_nx     = ST_DONE;
          alarm_cnt_nx = '0;
        end else if (ev_start) begin
          state_nx = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (ev_start) begin
          state_nx = ST_RUN;
        end else if (ev_mode) begin
          state_nx = ST_IDLE;
          clr_nx   = 1'b1;
        end
      end
      ST_DONE: begin
        if (ev_start || ev_mode || ev_inc) begin
          state_nx = ST_IDLE;
          clr_nx   = 1'b1;
        end else if (tick_1hz) begin
          if (alarm_cnt == ACW'(ALARM_TICKS - 1)) begin
            state_nx = ST_IDLE;
            clr_nx   = 1'b1;
          end else begin
            alarm_cnt_nx = alarm_cnt + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Display-facing outputs are derived from the next state so that, once
  // registered, they line up with state_dbg in the same cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      preset_min <= FIELD_W'(PRESET_MIN_DEF);
      preset_sec <= FIELD_W'(PRESET_SEC_DEF);
      alarm_cnt  <= '0;
      blink_ph   <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_load   <= 1'b0;
      cnt_clr    <= 1'b0;
      blink_min  <= 1'b0;
      blink_sec  <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nx;
      preset_min <= preset_min_nx;
      preset_sec <= preset_sec_nx;
      alarm_cnt  <= alarm_cnt_nx;
      blink_ph   <= blink_ph_nx;
      cnt_en     <= en_nx;
      cnt_load   <= load_nx;
      cnt_clr    <= clr_nx;
      blink_min  <= blink_ph_nx & (state_nx inside {ST_SET_MIN, ST_PAUSE, ST_DONE});
      blink_sec  <= blink_ph_nx & (state_nx inside {ST_SET_SEC, ST_PAUSE, ST_DONE});
      alarm      <= (state_nx == ST_DONE);
    end
  end

  assign load_min  = preset_min;
  assign load_sec  = preset_sec;
  assign state_dbg = state;

endmodule

// File: tb/tb_timer_control.sv
// Self-checking bench for timer_control: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_timer_control;

  localparam int D     = 4;
  localparam int ALARM = 10;
  localparam int S_IDLE = 0, S_SET_MIN = 1, S_SET_SEC = 2, S_RUN = 3, S_PAUSE = 4, S_DONE = 5;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic       cnt_zero = 1'b0;
  logic       cnt_en, cnt_load, cnt_clr, blink_min, blink_sec, alarm;
  logic [5:0] load_min, load_sec;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  bit run_chk = 1'b0;

  timer_control #(.DEB_CYC(D), .ALARM_TICKS(ALARM), .PRESET_MIN_DEF(1), .PRESET_SEC_DEF(0)) dut (
    .clk_in(clk_in), .reset(reset), .tick_1hz(tick_1hz),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_inc(btn_inc), .cnt_zero(cnt_zero),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_clr(cnt_clr),
    .load_min(load_min), .load_sec(load_sec),
    .blink_min(blink_min), .blink_sec(blink_sec), .alarm(alarm), .state_dbg(state_dbg));

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_st = S_IDLE, m_pmin = 1, m_psec = 0, m_ticks = 0;
  bit          m_ph = 0, m_en = 0, m_load = 0, m_clr = 0;
  bit          m_p [3];
  bit          m_lvl [3];
  logic [31:0] hist [3];

  function automatic int inc59(input int v);
    return (v + 1) % 60;
  endfunction

  task automatic model_step();
    bit es, em, ei;
    int ns;
    es = m_p[0];
    em = m_p[1] && !m_p[0];
    ei = m_p[2] && !m_p[0] && !m_p[1];
    ns = m_st;
    m_en = 0; m_load = 0; m_clr = 0;
    case (m_st)
      S_IDLE: begin
        if (es) begin
          if (m_pmin + m_psec > 0) begin ns = S_RUN; m_load = 1; end
        end else if (em) ns = S_SET_MIN;
      end
      S_SET_MIN: if (em) ns = S_SET_SEC; else if (ei) m_pmin = inc59(m_pmin);
      S_SET_SEC: if (em) ns = S_IDLE;    else if (ei) m_psec = inc59(m_psec);
      S_RUN: begin
        m_en = tick_1hz && !cnt_zero;
        if (cnt_zero) ns = S_DONE;
        else if (es) ns = S_PAUSE;
      end
      S_PAUSE: begin
        if (es) ns = S_RUN;
        else if (em) begin ns = S_IDLE; m_clr = 1; end
      end
      default: begin
        if (es || em || ei) begin ns = S_IDLE; m_clr = 1; end
        else if (tick_1hz) begin
          m_ticks++;
          if (m_ticks == ALARM) begin ns = S_IDLE; m_clr = 1; end
        end
      end
    endcase
    if (m_st != S_DONE && ns == S_DONE) m_ticks = 0;
    m_st = ns;
    if (tick_1hz) m_ph = !m_ph;
  endtask

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      m_st = S_IDLE; m_pmin = 1; m_psec = 0; m_ticks = 0;
      m_ph = 0; m_en = 0; m_load = 0; m_clr = 0;
      for (int b = 0; b < 3; b++) begin hist[b] = '0; m_lvl[b] = 0; m_p[b] = 0; end
    end else begin
      model_step();
      for (int b = 0; b < 3; b++) begin
        bit raw, all_new;
        raw = (b == 0) ? btn_start : (b == 1) ? btn_mode : btn_inc;
        hist[b] = {hist[b][30:0], raw};
        // A level is accepted once the synchronized input (two samples old)
        // has differed from the current level for D consecutive samples.
        all_new = 1;
        for (int k = 2; k <= D + 1; k++) if (hist[b][k] == m_lvl[b]) all_new = 0;
        m_p[b] = all_new && !m_lvl[b];
        if (all_new) m_lvl[b] = !m_lvl[b];
      end
    end
  end

  always @(negedge clk_in) begin
    if (run_chk) begin
      bit set_min_blank, set_sec_blank;
      set_min_blank = (m_st == S_SET_MIN || m_st == S_PAUSE || m_st == S_DONE);
      set_sec_blank = (m_st == S_SET_SEC || m_st == S_PAUSE || m_st == S_DONE);
      check("state_dbg", state_dbg, m_st);
      check("cnt_en", cnt_en, m_en);
      check("cnt_load", cnt_load, m_load);
      check("cnt_clr", cnt_clr, m_clr);
      check("load_min", load_min, m_pmin);
      check("load_sec", load_sec, m_psec);
      check("blink_min", blink_min, m_ph && set_min_blank);
      check("blink_sec", blink_sec, m_ph && set_sec_blank);
      check("alarm", alarm, m_st == S_DONE);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) btn_start = v;
    else if (b == 1) btn_mode = v;
    else btn_inc = v;
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    repeat (hold) step();
    set_btn(b, 1'b0);
  endtask

  task automatic settle();
    repeat (D + 6) step();
  endtask

  task automatic tap(input int b);
    press(b, D + 1);
    settle();
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state_dbg) != s && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check(name, state_dbg, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    logic prev;
    run_chk = 1'b1;
    #1 reset = 1'b0;
    repeat (3) step();
    check("reset_state", state_dbg, S_IDLE);
    check("reset_load_min", load_min, 1);
    check("reset_load_sec", load_sec, 0);
    check("reset_alarm", alarm, 0);
    reset = 1'b1;
    repeat (3) step();

    // Reset then start: load strobe with the default preset 01:00.
    press(0, D + 1);
    wait_state(S_RUN, 40, "start_to_run");
    check("start_load", cnt_load, 1);
    check("start_load_min", load_min, 1);
    check("start_load_sec", load_sec, 0);
    @(negedge clk_in);
    check("start_load_one_cycle", cnt_load, 0);
    settle();
    tick_once();
    @(negedge clk_in);
    check("run_cnt_en", cnt_en, 1);
    @(negedge clk_in);
    check("run_cnt_en_drop", cnt_en, 0);

    // Pause, resume without load, pause again and abort.
    press(0, D + 1);
    wait_state(S_PAUSE, 40, "run_to_pause");
    settle();
    tick_once();
    @(negedge clk_in);
    check("pause_cnt_en", cnt_en, 0);
    press(0, D + 1);
    wait_state(S_RUN, 40, "pause_to_run");
    check("resume_no_load", cnt_load, 0);
    settle();
    press(0, D + 1);
    wait_state(S_PAUSE, 40, "run_to_pause2");
    settle();
    press(1, D + 1);
    wait_state(S_IDLE, 40, "pause_abort");
    check("abort_clr", cnt_clr, 1);
    @(negedge clk_in);
    check("abort_clr_one_cycle", cnt_clr, 0);
    settle();

    // Preset editing with wrap.
    press(1, D + 1);
    wait_state(S_SET_MIN, 40, "idle_to_set_min");
    settle();
    prev = blink_min;
    tick_once();
    @(negedge clk_in);
    check("set_min_blink_toggle", blink_min, !prev);
    check("set_min_no_sec_blink", blink_sec, 0);
    repeat (59) tap(2);
    @(negedge clk_in);
    check("min_wrap", load_min, 0);
    press(1, D + 1);
    wait_state(S_SET_SEC, 40, "set_min_to_set_sec");
    settle();
    repeat (3) tap(2);
    @(negedge clk_in);
    check("sec_inc3", load_sec, 3);
    press(1, D + 1);
    wait_state(S_IDLE, 40, "set_sec_to_idle");
    settle();

    // Bounce rejection, then one clean 10-cycle press.
    repeat (3) begin
      press(0, 3);
      repeat (8) step();
    end
    @(negedge clk_in);
    check("bounce_no_change", state_dbg, S_IDLE);
    press(0, 10);
    wait_state(S_RUN, 40, "long_press_run");
    settle();
    repeat (20) step();
    check("long_press_single", state_dbg, S_RUN);

    // Expiry wins over a same-cycle start press and tick.
    @(negedge clk_in);
    set_btn(0, 1'b1);
    repeat (D + 2) step();
    tick_1hz = 1'b1;
    cnt_zero = 1'b1;
    step();
    tick_1hz = 1'b0;
    cnt_zero = 1'b0;
    @(negedge clk_in);
    check("expire_done", state_dbg, S_DONE);
    check("expire_alarm", alarm, 1);
    check("expire_no_en", cnt_en, 0);
    repeat (2) step();
    set_btn(0, 1'b0);
    settle();
    for (int i = 1; i < ALARM; i++) begin
      tick_once();
      repeat (3) step();
    end
    check("alarm_hold", state_dbg, S_DONE);
    tick_once();
    check("alarm_timeout_idle", state_dbg, S_IDLE);
    check("alarm_timeout_clr", cnt_clr, 1);
    check("alarm_timeout_off", alarm, 0);
    settle();

    // Zero preset: start is ignored.
    press(1, D + 1);
    wait_state(S_SET_MIN, 40, "zp_set_min");
    settle();
    press(1, D + 1);
    wait_state(S_SET_SEC, 40, "zp_set_sec");
    settle();
    repeat (57) tap(2);
    press(1, D + 1);
    wait_state(S_IDLE, 40, "zp_idle");
    settle();
    check("zp_preset_sec", load_sec, 0);
    check("zp_preset_min", load_min, 0);
    press(0, D + 1);
    seen = 0;
    repeat (16) begin
      @(negedge clk_in);
      if (cnt_load || state_dbg != 3'(S_IDLE)) seen = 1;
    end
    check("zero_preset_ignored", seen, 0);
    settle();

    // Async reset in the middle of a run.
    tap(1);
    tap(2);
    tap(1);
    tap(1);
    press(0, D + 1);
    wait_state(S_RUN, 40, "pre_reset_run");
    settle();
    tick_once();
    reset = 1'b0;
    #1;
    check("async_reset_state", state_dbg, S_IDLE);
    check("async_reset_en", cnt_en, 0);
    check("async_reset_alarm", alarm, 0);
    check("async_reset_min", load_min, 1);
    repeat (2) step();
    reset = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (cnt_load || cnt_clr || cnt_en || state_dbg != 3'(S_IDLE)) seen = 1;
    end
    check("release_no_strobe", seen, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      tick_1hz = ($urandom_range(0, 5) == 0);
      cnt_zero = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) btn_start = !btn_start;
      if ($urandom_range(0, 11) == 0) btn_mode = !btn_mode;
      if ($urandom_range(0, 11) == 0) btn_inc = !btn_inc;
      if (i == 1500) reset = 1'b0;
      if (i == 1503) reset = 1'b1;
    end
    step();
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
